// File: rtl/aer_spike_encoder.sv
`default_nettype none
// ============================================================================
// Module  : aer_spike_encoder
// Brief   : Rate-codes a stored 8-bit image into AER spike events (LFSR
//           threshold) over TIME_STEP timesteps, 4-phase REQ/ACK to the core.
//           Optional event counter output EVT_CNT: define SPK_ENC_EVT_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module aer_spike_encoder #(
  parameter int                   TIME_STEP      = 8,
  parameter int                   INPUT_NEURON   = 784,
  parameter int                   AER_WIDTH      = 12,
  parameter int                   PIX_ADDR_WIDTH = 10,
  parameter logic [AER_WIDTH-1:0] TS_MARKER      = 12'hFFF,
  parameter logic [15:0]          LFSR_SEED      = 16'hACE1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         PIX_WE,
  input  logic [PIX_ADDR_WIDTH-1:0]    PIX_ADDR,
  input  logic [7:0]                   PIX_DATA,
  input  logic                         START,
  output logic [AER_WIDTH-1:0]         AERIN_ADDR,
  output logic                         AERIN_REQ,
  input  logic                         AERIN_ACK,
  input  logic                         PROCESS_DONE,
  output logic                         BUSY,
  output logic                         DONE,
  output logic [$clog2(TIME_STEP)-1:0] TS_IDX
`ifdef SPK_ENC_EVT_CNT_EN
  ,
  output logic [15:0]                  EVT_CNT
`endif
);

  localparam int                        c_ts_w      = $clog2(TIME_STEP);
  localparam logic [15:0]               c_lfsr_taps = 16'hB400;
  localparam logic [PIX_ADDR_WIDTH-1:0] c_num_pix   = PIX_ADDR_WIDTH'(INPUT_NEURON);
  localparam logic [PIX_ADDR_WIDTH-1:0] c_last_pix  = PIX_ADDR_WIDTH'(INPUT_NEURON - 1);
  localparam logic [c_ts_w-1:0]         c_last_ts   = c_ts_w'(TIME_STEP - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD      = 4'd1,
    S_CMP     = 4'd2,
    S_REQ     = 4'd3,
    S_ACKL    = 4'd4,
    S_NEXT    = 4'd5,
    S_IDLE_TS = 4'd6,
    S_WAITD   = 4'd7,
    S_FIN     = 4'd8
  } state_t;

  state_t                    r_state;
  logic [PIX_ADDR_WIDTH-1:0] r_pix_idx;
  logic [c_ts_w-1:0]         r_ts;
  logic [15:0]               r_lfsr;
  logic                      r_marker;
  logic [7:0]                r_mem [INPUT_NEURON];
  logic [7:0]                r_pix_q;

  logic                      w_wr_en;
  logic [15:0]               w_lfsr_nxt;
  logic                      w_spike;
  logic [AER_WIDTH-1:0]      w_pix_aer;

  assign w_wr_en    = PIX_WE && (r_state == S_IDLE) && (PIX_ADDR < c_num_pix);
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_taps : 16'h0000);
  assign w_spike    = (r_pix_q == 8'hFF) || (r_pix_q > r_lfsr[7:0]);
  assign w_pix_aer  = {{(AER_WIDTH - PIX_ADDR_WIDTH){1'b0}}, r_pix_idx};
  assign TS_IDX     = r_ts;

  // Pixel store: one write port, registered read valid in CMP after RD.
  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[PIX_ADDR] <= PIX_DATA;
    r_pix_q <= r_mem[r_pix_idx];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_pix_idx  <= '0;
      r_ts       <= '0;
      r_lfsr     <= LFSR_SEED;
      r_marker   <= 1'b0;
      AERIN_ADDR <= '0;
      AERIN_REQ  <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_pix_idx <= '0;
            r_ts      <= '0;
            r_lfsr    <= LFSR_SEED;
            BUSY      <= 1'b1;
            r_state   <= S_RD;
          end
        end
        S_RD: r_state <= S_CMP;
        S_CMP: begin
          r_lfsr <= w_lfsr_nxt;
          if (w_spike) begin
            AERIN_ADDR <= w_pix_aer;
            AERIN_REQ  <= 1'b1;
            r_marker   <= 1'b0;
            r_state    <= S_REQ;
          end else begin
            r_state <= S_NEXT;
          end
        end
        S_REQ: begin
          if (AERIN_ACK) begin
            AERIN_REQ <= 1'b0;
            r_state   <= S_ACKL;
          end
        end
        S_ACKL: begin
          if (!AERIN_ACK) r_state <= r_marker ? S_IDLE_TS : S_NEXT;
        end
        S_NEXT: begin
          if (r_pix_idx == c_last_pix) begin
            AERIN_ADDR <= TS_MARKER;
            AERIN_REQ  <= 1'b1;
            r_marker   <= 1'b1;
            r_state    <= S_REQ;
          end else begin
            r_pix_idx <= r_pix_idx + 1'b1;
            r_state   <= S_RD;
          end
        end
        S_IDLE_TS: begin
          if (r_ts == c_last_ts) begin
            r_state <= S_WAITD;
          end else begin
            r_ts      <= r_ts + 1'b1;
            r_pix_idx <= '0;
            r_state   <= S_RD;
          end
        end
        S_WAITD: begin
          if (PROCESS_DONE) begin
            DONE    <= 1'b1;
            BUSY    <= 1'b0;
            r_state <= S_FIN;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SPK_ENC_EVT_CNT_EN
  logic [15:0] r_evt_cnt;

  // A spike handshake counts once ACK has returned low; markers are skipped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_evt_cnt <= '0;
    end else if ((r_state == S_IDLE) && START) begin
      r_evt_cnt <= '0;
    end else if ((r_state == S_ACKL) && !AERIN_ACK && !r_marker && (r_evt_cnt != 16'hFFFF)) begin
      r_evt_cnt <= r_evt_cnt + 16'd1;
    end
  end

  assign EVT_CNT = r_evt_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aer_spike_encoder.sv
`default_nettype none
// Bench for aer_spike_encoder: scenario table driving a reference-model
// scoreboard of AER events, plus reset-mid-handshake sequences.
module tb_aer_spike_encoder;
  localparam int          NPIX   = 784;
  localparam int          NTS    = 8;
  localparam logic [11:0] MARKER = 12'hFFF;

  logic        CLK = 1'b0;
  logic        RST, PIX_WE, START, AERIN_ACK, PROCESS_DONE;
  logic [9:0]  PIX_ADDR;
  logic [7:0]  PIX_DATA;
  logic [11:0] AERIN_ADDR;
  logic        AERIN_REQ, BUSY, DONE;
  logic [2:0]  TS_IDX;
`ifdef SPK_ENC_EVT_CNT_EN
  logic [15:0] EVT_CNT;
`endif

  aer_spike_encoder dut (
    .CLK(CLK), .RST(RST), .PIX_WE(PIX_WE), .PIX_ADDR(PIX_ADDR), .PIX_DATA(PIX_DATA),
    .START(START), .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ), .AERIN_ACK(AERIN_ACK),
    .PROCESS_DONE(PROCESS_DONE), .BUSY(BUSY), .DONE(DONE), .TS_IDX(TS_IDX)
`ifdef SPK_ENC_EVT_CNT_EN
    , .EVT_CNT(EVT_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int pat;        // 0 all-zero load, 1 pixel 5 = 255, 2 random load, 3 keep image
    int ack_dly;
    int stall;      // ACK delay for the first event only
    int hold;       // cycles ACK stays high
    int disturb;    // 1 early PROCESS_DONE, 2 START + PIX_WE while busy
    int exp_events; // -1 -> reference model count
    int exp_cnt;    // -1 -> reference model spike count
  } scen_t;

  int          n_vec = 0, n_err = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  img [NPIX];
  int          n_obs, n_exp, n_spk_model;
  int          rsp_en = 0, rsp_busy = 0, ack_delay = 0, stall_next = 0, ack_hold = 1;
  logic [11:0] rsp_got;
  int          rsp_dly;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic write_pix(input logic [9:0] a, input logic [7:0] d);
    PIX_WE = 1'b1; PIX_ADDR = a; PIX_DATA = d;
    tick();
    PIX_WE = 1'b0;
    if (int'(a) < NPIX) img[a] = d;
  endtask

  // Reference model: Galois LFSR, right shift, taps B400, one step per pixel.
  task automatic build_model();
    logic [15:0] lf;
    lf = 16'hACE1;
    exp_q.delete();
    n_spk_model = 0;
    for (int t = 0; t < NTS; t++) begin
      for (int p = 0; p < NPIX; p++) begin
        logic sp;
        sp = (img[p] == 8'd255) || (img[p] > lf[7:0]);
        lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
        if (sp) begin
          exp_q.push_back(12'(p));
          n_spk_model++;
        end
      end
      exp_q.push_back(MARKER);
    end
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Core-side responder: pops and compares each event, then runs the handshake.
  initial begin
    AERIN_ACK = 1'b0;
    forever begin
      tick();
      if (rsp_en != 0 && AERIN_REQ === 1'b1 && RST === 1'b0) begin
        rsp_busy = 1;
        rsp_got  = AERIN_ADDR;
        n_obs++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_event: got %03h, expected none", rsp_got);
        end else begin
          check("event_addr", 32'(rsp_got), 32'(exp_q.pop_front()));
        end
        rsp_dly    = (stall_next > 0) ? stall_next : ack_delay;
        stall_next = 0;
        for (int i = 0; i < rsp_dly; i++) begin
          tick();
          check("req_held", 32'(AERIN_REQ), 32'd1);
          check("addr_held", 32'(AERIN_ADDR), 32'(rsp_got));
        end
        AERIN_ACK = 1'b1;
        tick();
        check("req_drop_on_ack", 32'(AERIN_REQ), 32'd0);
        for (int i = 0; i < ack_hold - 1; i++) begin
          tick();
          check("no_req_while_ack_high", 32'(AERIN_REQ), 32'd0);
        end
        AERIN_ACK = 1'b0;
        rsp_busy  = 0;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    scen_t tbl[4];
    int    timeout, early, reached;
    tbl[0] = '{0, 2, 0,  1, 1,  8, 0};
    tbl[1] = '{1, 1, 50, 3, 0, 16, 8};
    tbl[2] = '{2, 0, 0,  1, 0, -1, -1};
    tbl[3] = '{3, 0, 0,  1, 2, -1, -1};

    RST = 1'b1; PIX_WE = 1'b0; START = 1'b0; PROCESS_DONE = 1'b0;
    PIX_ADDR = '0; PIX_DATA = '0;
    #2;
    check("rst_req", 32'(AERIN_REQ), 32'd0);
    check("rst_addr", 32'(AERIN_ADDR), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_ts_idx", 32'(TS_IDX), 32'd0);
    tick(); tick();
    RST = 1'b0;
    tick();

    for (int s = 0; s < 4; s++) begin
      if (tbl[s].pat == 0) begin
        for (int p = 0; p < NPIX; p++) write_pix(10'(p), 8'd0);
      end else if (tbl[s].pat == 1) begin
        write_pix(10'd5, 8'd255);
        write_pix(10'd1000, 8'd255);
      end else if (tbl[s].pat == 2) begin
        for (int p = 0; p < NPIX; p++)
          write_pix(10'(p), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0);
        write_pix(10'd0, 8'd0);
        write_pix(10'd1, 8'd255);
        write_pix(10'd783, 8'd1);
      end
      build_model();
      n_exp = exp_q.size(); n_obs = 0;
      ack_delay = tbl[s].ack_dly; stall_next = tbl[s].stall; ack_hold = tbl[s].hold;
      rsp_en = 1;
      pulse_start();
      check("busy_after_start", 32'(BUSY), 32'd1);
      check("ts_idx_after_start", 32'(TS_IDX), 32'd0);

      early = 0; timeout = 1;
      for (int c = 0; c < 60000; c++) begin
        tick();
        if (DONE === 1'b1) early = 1;
        if (c == 100 && tbl[s].disturb == 1) begin
          PROCESS_DONE = 1'b1; tick(); PROCESS_DONE = 1'b0;
        end
        if (c == 100 && tbl[s].disturb == 2) begin
          START = 1'b1; PIX_WE = 1'b1; PIX_ADDR = 10'd0; PIX_DATA = 8'hFF;
          tick();
          START = 1'b0; PIX_WE = 1'b0;
        end
        if (exp_q.size() == 0 && n_obs == n_exp && rsp_busy == 0) begin
          timeout = 0;
          break;
        end
      end
      check("events_timeout", 32'(timeout), 32'd0);
      check("event_count", 32'(n_obs), 32'((tbl[s].exp_events >= 0) ? tbl[s].exp_events : n_exp));
      repeat (4) tick();
      check("no_early_done", 32'(early), 32'd0);
      check("waitd_done_low", 32'(DONE), 32'd0);
      check("waitd_busy_high", 32'(BUSY), 32'd1);
      check("waitd_ts_idx", 32'(TS_IDX), 32'(NTS - 1));
      PROCESS_DONE = 1'b1;
      tick();
      PROCESS_DONE = 1'b0;
      check("done_pulse", 32'(DONE), 32'd1);
      check("busy_low_at_done", 32'(BUSY), 32'd0);
      tick();
      check("done_one_cycle", 32'(DONE), 32'd0);
      check("ts_idx_held", 32'(TS_IDX), 32'(NTS - 1));
`ifdef SPK_ENC_EVT_CNT_EN
      check("evt_cnt", 32'(EVT_CNT), 32'((tbl[s].exp_cnt >= 0) ? tbl[s].exp_cnt : n_spk_model));
`endif
    end

    // Reset during a pending request in timestep 2.
    build_model(); n_exp = exp_q.size(); n_obs = 0;
    ack_delay = 0; ack_hold = 1; rsp_en = 1;
    pulse_start();
    reached = 0;
    for (int c = 0; c < 30000; c++) begin
      tick();
      if (TS_IDX == 3'd2) begin reached = 1; break; end
    end
    check("reach_ts2", 32'(reached), 32'd1);
    rsp_en = 0;
    reached = 0;
    for (int c = 0; c < 30000; c++) begin
      tick();
      if (rsp_busy == 0 && AERIN_REQ === 1'b1) begin reached = 1; break; end
    end
    check("req_pending_before_rst", 32'(reached), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("rst_async_req", 32'(AERIN_REQ), 32'd0);
    check("rst_async_busy", 32'(BUSY), 32'd0);
    check("rst_async_ts_idx", 32'(TS_IDX), 32'd0);
    tick(); tick();
    RST = 1'b0;
    repeat (3) tick();
    check("no_done_after_rst", 32'(DONE), 32'd0);

    build_model(); n_exp = exp_q.size(); n_obs = 0;
    rsp_en = 1;
    pulse_start();
    check("restart_busy", 32'(BUSY), 32'd1);
    check("restart_ts_idx", 32'(TS_IDX), 32'd0);
    reached = 0;
    for (int c = 0; c < 5000; c++) begin
      tick();
      if (n_obs >= 30 && rsp_busy == 0) begin reached = 1; break; end
    end
    check("restart_events", 32'(reached), 32'd1);
    rsp_en = 0;
    for (int c = 0; c < 100 && rsp_busy != 0; c++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    check("final_busy", 32'(BUSY), 32'd0);
    check("final_req", 32'(AERIN_REQ), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
